// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO feeding a UART transmitter: one start pulse per byte,
// waits for the transmitter's done, and a watchdog abandons a byte whose done never comes.
module uart_tx_fifo #(
  parameter int NB_DATA     = 8,
  parameter int DEPTH_LOG2  = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [NB_DATA-1:0]    i_wr_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_tx_start,
  output logic [NB_DATA-1:0]    o_tx_data,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic                  o_timeout
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT_DONE} state_t;

  state_t                  state_reg, state_next;
  logic [NB_DATA-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH_LOG2:0]     count_reg;
  logic [WD_W-1:0]         wd_reg, wd_next;
  logic [NB_DATA-1:0]      tx_data_reg;
  logic                    tx_start_reg, tx_start_next;
  logic                    timeout_reg, timeout_next;
  logic                    overflow_reg;
  logic                    push, pop;

  // Status flags come from the occupancy register alone, so they are glitch-free.
  assign o_count    = count_reg;
  assign o_full     = (count_reg == FULL_CNT);
  assign o_empty    = (count_reg == '0);
  assign o_overflow = overflow_reg;
  assign o_tx_start = tx_start_reg;
  assign o_tx_data  = tx_data_reg;
  assign o_timeout  = timeout_reg;
  assign o_busy     = (state_reg != IDLE);

  // A pop in the same cycle does not rescue a write that sees the FIFO full.
  assign push = i_wr_en & ~o_full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      tx_data_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      overflow_reg <= i_wr_en & o_full;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + PTR_ONE;
        tx_data_reg <= mem[rd_ptr_reg];
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg    <= IDLE;
      wd_reg       <= '0;
      tx_start_reg <= 1'b0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wd_reg       <= wd_next;
      tx_start_reg <= tx_start_next;
      timeout_reg  <= timeout_next;
    end
  end

  // Start is registered on entry to START so it lines up exactly with that state.
  always_comb begin
    state_next    = state_reg;
    wd_next       = wd_reg;
    tx_start_next = 1'b0;
    timeout_next  = 1'b0;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!o_empty) begin
          pop        = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        tx_start_next = 1'b1;
        state_next    = START;
      end
      START: begin
        wd_next    = '0;
        state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (i_tx_done) begin
          state_next = IDLE;
        end else if (wd_reg == WD_LAST) begin
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          wd_next = wd_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: cycle table for the basic handshake, then
// sequences for full/overflow, burst ordering, pointer wrap, watchdog and reset.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en, tx_done;
  logic [7:0] wr_data;
  logic       full, empty, overflow, tx_start, busy, timeout;
  logic [4:0] count;
  logic [7:0] tx_data;

  logic       t_wr_en, t_tx_done;
  logic [7:0] t_wr_data;
  logic       t_full, t_empty, t_overflow, t_tx_start, t_busy, t_timeout;
  logic [4:0] t_count;
  logic [7:0] t_tx_data;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [7:0] mq[$];
  int start_edge[$];
  int done_edge[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.NB_DATA(8), .DEPTH_LOG2(4), .TIMEOUT_CYC(65535)) dut (
    .clk(clk), .i_rst(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_full(full), .o_empty(empty), .o_count(count), .o_overflow(overflow),
    .o_tx_start(tx_start), .o_tx_data(tx_data), .i_tx_done(tx_done),
    .o_busy(busy), .o_timeout(timeout)
  );

  uart_tx_fifo #(.NB_DATA(8), .DEPTH_LOG2(4), .TIMEOUT_CYC(8)) dut_to (
    .clk(clk), .i_rst(rst), .i_wr_en(t_wr_en), .i_wr_data(t_wr_data),
    .o_full(t_full), .o_empty(t_empty), .o_count(t_count), .o_overflow(t_overflow),
    .o_tx_start(t_tx_start), .o_tx_data(t_tx_data), .i_tx_done(t_tx_done),
    .o_busy(t_busy), .o_timeout(t_timeout)
  );

  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      mq.push_back(tx_data);
      $display("tx byte %02h at cycle %0d", tx_data, cyc);
    end
  end

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_done;
    logic [4:0] e_count;
    logic       e_busy;
    logic       e_start;
    logic [7:0] e_data;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  // Waits for each start pulse, then answers with done dly cycles later.
  task automatic serve(input int n, input int dly);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (tx_start !== 1'b1 && w < 20) begin
        tick();
        w++;
      end
      if (tx_start !== 1'b1) begin
        check("start_wait", 32'd0, 32'd1);
        return;
      end
      start_edge.push_back(cyc);
      repeat (dly) tick();
      tx_done = 1'b1;
      tick();
      done_edge.push_back(cyc);
      tx_done = 1'b0;
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'hA5, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'hA5, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'hA5, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'hA5, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[7]  = '{1'b1, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'h3C, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h3C, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 8'h3C, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'h3C, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 8'h3C, 1'b0};
    vecs[13] = '{1'b1, 8'h01, 1'b0, 5'd1, 1'b0, 1'b0, 8'h3C, 1'b0};
    vecs[14] = '{1'b1, 8'h02, 1'b0, 5'd1, 1'b1, 1'b0, 8'h01, 1'b0};
    vecs[15] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 1'b1, 8'h01, 1'b0};
    vecs[16] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b1, 1'b0, 8'h01, 1'b0};
    vecs[17] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 8'h01, 1'b0};
    vecs[18] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'h02, 1'b0};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 8'h02, 1'b0};
    vecs[20] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 8'h02, 1'b0};
    vecs[21] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 8'h02, 1'b0};

    rst = 1'b1; wr_en = 1'b0; wr_data = '0; tx_done = 1'b0;
    t_wr_en = 1'b0; t_wr_data = '0; t_tx_done = 1'b0;
    tick(); tick();
    check("rst_outputs", {count, empty, full, busy, tx_start, tx_data, overflow, timeout},
          {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    rst = 1'b0;
    tick();

    // Cycle table: single byte, done ignored in IDLE and START, write+pop same cycle.
    for (int i = 0; i < 22; i++) begin
      wr_en   = vecs[i].wr_en;
      wr_data = vecs[i].wr_data;
      tx_done = vecs[i].tx_done;
      tick();
      $display("vec %0d: count=%0d busy=%b start=%b data=%02h ovf=%b",
               i, count, busy, tx_start, tx_data, overflow);
      check($sformatf("vec%0d", i),
            {count, empty, full, busy, tx_start, tx_data, overflow},
            {vecs[i].e_count, vecs[i].e_count == 5'd0, vecs[i].e_count == 5'd16,
             vecs[i].e_busy, vecs[i].e_start, vecs[i].e_data, vecs[i].e_ovf});
    end
    wr_en = 1'b0; tx_done = 1'b0;

    // Fill to full with byte 0 in flight, then overflow and write-while-full-with-pop.
    mq.delete();
    for (int i = 0; i < 17; i++) wr(8'(i));
    check("full_flag", {31'd0, full}, 32'd1);
    check("full_count", {27'd0, count}, 32'd16);
    wr(8'hFF);
    check("ovf_pulse", {31'd0, overflow}, 32'd1);
    check("ovf_count", {27'd0, count}, 32'd16);
    tick();
    check("ovf_clear", {31'd0, overflow}, 32'd0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("done_to_idle", {31'd0, busy}, 32'd0);
    wr(8'hEE);
    check("pop_full_ovf", {31'd0, overflow}, 32'd1);
    check("pop_full_count", {27'd0, count}, 32'd15);
    check("pop_full_busy", {31'd0, busy}, 32'd1);
    serve(16, 1);
    check("full_drain_n", mq.size(), 32'd17);
    for (int i = 0; i < 17 && i < mq.size(); i++)
      check($sformatf("full_byte%0d", i), {24'd0, mq[i]}, i);
    check("full_drain_empty", {31'd0, empty}, 32'd1);

    // Burst of three, done 10 cycles after each start.
    mq.delete(); start_edge.delete(); done_edge.delete();
    fork
      begin wr(8'h11); wr(8'h22); wr(8'h33); end
      serve(3, 10);
    join
    check("burst_n", mq.size(), 32'd3);
    if (mq.size() == 3) begin
      check("burst_b0", {24'd0, mq[0]}, 32'h11);
      check("burst_b1", {24'd0, mq[1]}, 32'h22);
      check("burst_b2", {24'd0, mq[2]}, 32'h33);
    end
    for (int i = 1; i < start_edge.size() && i < done_edge.size(); i++)
      check($sformatf("burst_gap%0d", i), start_edge[i] - done_edge[i-1], 32'd2);

    // Forty bytes through the pointers in chunks of ten.
    mq.delete();
    for (int c = 0; c < 4; c++) begin
      fork
        begin
          for (int j = 0; j < 10; j++) wr(8'(((c * 10 + j) * 37 + 5) % 256));
        end
        serve(10, 1);
      join
    end
    check("wrap_n", mq.size(), 32'd40);
    for (int i = 0; i < 40 && i < mq.size(); i++)
      check($sformatf("wrap_byte%0d", i), {24'd0, mq[i]}, (i * 37 + 5) % 256);

    // Watchdog on the short-timeout instance.
    begin
      int s, e, w;
      t_wr_en = 1'b1; t_wr_data = 8'h5A; tick();
      t_wr_data = 8'h6B; tick();
      t_wr_en = 1'b0;
      w = 0;
      while (t_tx_start !== 1'b1 && w < 20) begin tick(); w++; end
      check("to_start", {31'd0, t_tx_start}, 32'd1);
      check("to_data", {24'd0, t_tx_data}, 32'h5A);
      s = cyc;
      w = 0;
      while (t_timeout !== 1'b1 && w < 30) begin tick(); w++; end
      e = cyc;
      check("to_pulse", {31'd0, t_timeout}, 32'd1);
      check("to_delay", e - s, 32'd9);
      check("to_idle", {31'd0, t_busy}, 32'd0);
      tick();
      check("to_clear", {31'd0, t_timeout}, 32'd0);
      tick();
      check("to_next_start", {31'd0, t_tx_start}, 32'd1);
      check("to_next_data", {24'd0, t_tx_data}, 32'h6B);
      check("to_next_empty", {31'd0, t_empty}, 32'd1);
    end

    // Asynchronous reset while waiting for done with three bytes queued.
    begin
      int starts = 0;
      wr(8'h71); wr(8'h72); wr(8'h73); wr(8'h74);
      check("pre_rst", {27'd0, count, busy}, {26'd0, 5'd3, 1'b1});
      #2 rst = 1'b1;
      #1;
      check("rst_async", {count, empty, full, busy, tx_start, tx_data},
            {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (tx_start === 1'b1) starts++;
      end
      check("post_rst_starts", starts, 32'd0);
      check("post_rst_state", {30'd0, empty, busy}, {30'd0, 1'b1, 1'b0});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
